// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss handler sitting between the cache arrays and a pipelined, multi-cycle
// main memory. When the cache reports a miss, the handler fetches the whole
// block one word per cycle. Each returned word is written into the cache data
// array. The tag/valid entry is written on the final returned word. The
// processor stalls on fsm_busy for the whole fill.
//
// Parameters
//   AWIDTH           byte-address width
//   DWIDTH           data word width
//   WORDS_PER_BLOCK  words per cache block (power of two, >= 2)
//   MEM_LATENCY      cycles from address issue to memory_valid
//
// Ports
//   clk                in   single clock, rising edge
//   rst                in   synchronous active-high reset
//   miss_detected      in   cache reports a miss this cycle
//   miss_address       in   byte address that missed
//   memory_valid       in   memory_data_out carries returned data this cycle
//   memory_data_out    in   data returned by main memory
//   fsm_busy           out  fill in progress (processor stall)
//   mem_enable         out  memory_address is a valid read request
//   memory_address     out  word read address issued to main memory
//   write_data_array   out  write cache_data at cache_word_offset
//   write_tag_array    out  write tag/valid for the block
//   cache_word_offset  out  word index within the block being written
//   cache_data         out  data to write into the cache data array
//
// Outputs are decoded from registered state in the same cycle. The return-side
// outputs also follow memory_valid in the same cycle. This gives the fixed
// timing the cache expects: write on the cycle the data arrives, and tag
// together with the last word.
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int AWIDTH          = 16,
    parameter int DWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [AWIDTH-1:0]                  miss_address,
    input  logic                               memory_valid,
    input  logic [DWIDTH-1:0]                  memory_data_out,
    output logic                               fsm_busy,
    output logic                               mem_enable,
    output logic [AWIDTH-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_offset,
    output logic [DWIDTH-1:0]                  cache_data
);

    // Word-offset width and issue-counter width. The issue counter must
    // reach WORDS_PER_BLOCK, so it needs one extra bit over the offset.
    localparam int OFFW = $clog2(WORDS_PER_BLOCK);
    localparam int ICW  = $clog2(WORDS_PER_BLOCK + 1);

    // Clears the byte-in-block bits of the miss address (block = 2*words bytes).
    localparam logic [AWIDTH-1:0] BLOCK_MASK = ~AWIDTH'(2 * WORDS_PER_BLOCK - 1);

    localparam logic [ICW-1:0]  IC_LAST = ICW'(WORDS_PER_BLOCK);
    localparam logic [OFFW-1:0] RC_LAST = OFFW'(WORDS_PER_BLOCK - 1);

    // Elaboration-time sanity on the configuration.
    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_wpb
        $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of two >= 2");
    end
    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [ICW-1:0]    ic_r,    ic_s;     // issue counter, 0..WORDS_PER_BLOCK
    logic [OFFW-1:0]   rc_r,    rc_s;     // receive counter, 0..WORDS_PER_BLOCK-1
    logic [AWIDTH-1:0] base_r,  base_s;   // block-aligned byte address of the fill

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ic_r    <= {ICW{1'b0}};
            rc_r    <= {OFFW{1'b0}};
            base_r  <= {AWIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            ic_r    <= ic_s;
            rc_r    <= rc_s;
            base_r  <= base_s;
        end
    end

    // Next-state, counter updates and output decode.
    always_comb begin
        state_s           = state_r;
        ic_s              = ic_r;
        rc_s              = rc_r;
        base_s            = base_r;
        fsm_busy          = 1'b0;
        mem_enable        = 1'b0;
        memory_address    = {AWIDTH{1'b0}};
        write_data_array  = 1'b0;
        write_tag_array   = 1'b0;
        cache_word_offset = {OFFW{1'b0}};
        cache_data        = {DWIDTH{1'b0}};

        case (state_r)
            IDLE: begin
                // memory_valid is deliberately ignored here: nothing is in flight.
                if (miss_detected) begin
                    base_s  = miss_address & BLOCK_MASK;
                    ic_s    = {ICW{1'b0}};
                    rc_s    = {OFFW{1'b0}};
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;

                // Issue side: one read per cycle until the whole block is
                // requested. The block is aligned, so the add never carries
                // out of the block.
                if (ic_r < IC_LAST) begin
                    mem_enable     = 1'b1;
                    memory_address = base_r + AWIDTH'({ic_r, 1'b0});
                    ic_s           = ic_r + ICW'(1);
                end else begin
                    mem_enable     = 1'b0;
                    ic_s           = ic_r;
                end

                // Return side: depends only on the receive counter. It can
                // overlap with issue in the same cycle.
                if (memory_valid) begin
                    write_data_array  = 1'b1;
                    cache_word_offset = rc_r;
                    cache_data        = memory_data_out;
                    rc_s              = rc_r + OFFW'(1);
                    if (rc_r == RC_LAST) begin
                        write_tag_array = 1'b1;
                        state_s         = IDLE;
                    end else begin
                        write_tag_array = 1'b0;
                        state_s         = FILL;
                    end
                end else begin
                    rc_s    = rc_r;
                    state_s = FILL;
                end
                // miss_detected is ignored for the whole fill; the cache keeps
                // it asserted and it is taken in the first IDLE cycle.
            end

            default: begin
                state_s = IDLE;
                ic_s    = {ICW{1'b0}};
                rc_s    = {OFFW{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm. Two instances share clk/rst: instance 0 uses
// MEM_LATENCY=4 and instance 1 uses MEM_LATENCY=1. Each instance has its own
// pipelined memory model. Expected outputs come from the timing rules of a
// fill, expressed as plain cycle arithmetic relative to the miss cycle.
module tb_cache_fill_fsm;

    localparam int NI = 2;
    localparam int W  = 8;

    logic        clk;
    logic        rst;
    logic        miss_detected     [NI];
    logic [15:0] miss_address      [NI];
    logic        memory_valid      [NI];
    logic [15:0] memory_data_out   [NI];
    logic        fsm_busy          [NI];
    logic        mem_enable        [NI];
    logic [15:0] memory_address    [NI];
    logic        write_data_array  [NI];
    logic        write_tag_array   [NI];
    logic [2:0]  cache_word_offset [NI];
    logic [15:0] cache_data        [NI];
    logic        inj_v             [NI];
    logic [15:0] inj_d             [NI];
    logic [15:0] salt;

    int total;
    int bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 4 : 1;
        logic        pv [LAT];
        logic [15:0] pa [LAT];

        cache_fill_fsm #(
            .AWIDTH(16), .DWIDTH(16), .WORDS_PER_BLOCK(W), .MEM_LATENCY(LAT)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .miss_detected     (miss_detected[g]),
            .miss_address      (miss_address[g]),
            .memory_valid      (memory_valid[g]),
            .memory_data_out   (memory_data_out[g]),
            .fsm_busy          (fsm_busy[g]),
            .mem_enable        (mem_enable[g]),
            .memory_address    (memory_address[g]),
            .write_data_array  (write_data_array[g]),
            .write_tag_array   (write_tag_array[g]),
            .cache_word_offset (cache_word_offset[g]),
            .cache_data        (cache_data[g])
        );

        // Pipelined memory: a read issued in cycle n returns in cycle n+LAT.
        // The contents are addr ^ salt. The memory shares rst.
        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < LAT; k++) begin
                    pv[k] <= 1'b0;
                    pa[k] <= 16'h0;
                end
            end else begin
                pv[0] <= mem_enable[g];
                pa[0] <= memory_address[g];
                for (int k = 1; k < LAT; k++) begin
                    pv[k] <= pv[k-1];
                    pa[k] <= pa[k-1];
                end
            end
        end

        assign memory_valid[g]    = pv[LAT-1] | inj_v[g];
        assign memory_data_out[g] = pv[LAT-1] ? (pa[LAT-1] ^ salt) : inj_d[g];
    end

    task automatic chk(input string tag, input int g, input int r,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s inst=%0d cyc=%0d observed=0x%0h expected=0x%0h",
                   tag, g, r, obs, exp);
        end
    endtask

    task automatic chk_all(input int g, input int r, input logic e_busy,
                           input logic e_me, input logic [15:0] e_ad,
                           input logic e_wd, input logic [2:0] e_off,
                           input logic [15:0] e_dat, input logic e_wt);
        chk("fsm_busy",          g, r, 32'(fsm_busy[g]),          32'(e_busy));
        chk("mem_enable",        g, r, 32'(mem_enable[g]),        32'(e_me));
        chk("memory_address",    g, r, 32'(memory_address[g]),    32'(e_ad));
        chk("write_data_array",  g, r, 32'(write_data_array[g]),  32'(e_wd));
        chk("cache_word_offset", g, r, 32'(cache_word_offset[g]), 32'(e_off));
        chk("cache_data",        g, r, 32'(cache_data[g]),        32'(e_dat));
        chk("write_tag_array",   g, r, 32'(write_tag_array[g]),   32'(e_wt));
    endtask

    // One fill on instance g, starting with a miss in relative cycle 0.
    // ign_from > 0 keeps a second miss (ign_addr) asserted from that cycle
    // to the end of the fill. rst_at >= 0 pulses rst in that cycle.
    task automatic do_fill(input int g, input logic [15:0] a, input int lat,
                           input int ign_from, input logic [15:0] ign_addr,
                           input int rst_at);
        int          base;
        int          j;
        logic [15:0] e_ad;
        logic [15:0] e_dat;
        base = int'(a) - (int'(a) % (2 * W));
        for (int r = 0; r <= W + lat; r++) begin
            @(negedge clk);
            rst = (r == rst_at);
            if (r == 0) begin
                miss_detected[g] = 1'b1;
                miss_address[g]  = a;
            end else if (ign_from > 0 && r >= ign_from) begin
                miss_detected[g] = 1'b1;
                miss_address[g]  = ign_addr;
            end else begin
                miss_detected[g] = 1'b0;
                miss_address[g]  = 16'($urandom);
            end
            #1;
            if (rst_at >= 0 && r > rst_at) begin
                chk_all(g, r, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
            end else begin
                j     = r - 1 - lat;
                e_ad  = (r >= 1 && r <= W) ? 16'(base + 2 * (r - 1)) : 16'h0;
                e_dat = (j >= 0 && j < W) ? (16'(base + 2 * j) ^ salt) : 16'h0;
                chk_all(g, r,
                        (r >= 1 && r <= W + lat),
                        (r >= 1 && r <= W), e_ad,
                        (j >= 0 && j < W), (j >= 0 && j < W) ? 3'(j) : 3'd0,
                        e_dat,
                        (r == W + lat));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        salt  = 16'($urandom);
        rst   = 1'b1;
        for (int g = 0; g < NI; g++) begin
            miss_detected[g] = 1'b1;      // rst must win over a simultaneous miss
            miss_address[g]  = 16'h5555;
            inj_v[g]         = 1'b0;
            inj_d[g]         = 16'h0;
        end
        repeat (3) @(negedge clk);

        // Reset state: everything 0, the miss presented under reset not taken.
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NI; g++) miss_detected[g] = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) chk_all(g, -1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);

        // Basic fill, then block alignment at the top of the address space.
        do_fill(0, 16'h1236, 4, 0, 16'h0, -1);
        do_fill(0, 16'hFFFF, 4, 0, 16'h0, -1);

        // Miss during fill (including final-data cycle) ignored, taken at cycle 13.
        do_fill(0, 16'h1230, 4, 7, 16'h4000, -1);
        do_fill(0, 16'h4000, 4, 0, 16'h0, -1);

        // Spurious memory_valid while idle: no writes.
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            miss_detected[g] = 1'b0;
            inj_v[g]         = 1'b1;
            inj_d[g]         = 16'hDEAD;
        end
        #1;
        for (int g = 0; g < NI; g++) chk_all(g, -2, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
        @(negedge clk);
        for (int g = 0; g < NI; g++) inj_v[g] = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) chk_all(g, -3, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);

        // Reset in cycle 6 of a fill, then a clean complete fill.
        do_fill(0, 16'h2468, 4, 0, 16'h0, 6);
        do_fill(0, 16'h2468, 4, 0, 16'h0, -1);

        // Randomized back-to-back fills.
        repeat (6) do_fill(0, 16'($urandom), 4, 0, 16'h0, -1);

        // MEM_LATENCY=1 instance: data in cycles 2-9, tag in 9, idle in 10.
        do_fill(1, 16'h1236, 1, 0, 16'h0, -1);
        repeat (3) do_fill(1, 16'($urandom), 1, 0, 16'h0, -1);

        // Both instances back to idle after the last fill.
        @(negedge clk);
        for (int g = 0; g < NI; g++) miss_detected[g] = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) chk_all(g, -4, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss handler between the WISC-FA24 cache arrays and the multi-cycle main memory. On a cache miss it fetches the whole 16-byte block (8 words) from pipelined main memory. It writes each returned word into the cache data array, then writes the tag on the final word. While a fill is in progress it holds `fsm_busy` high, and the processor stalls on that signal.

## Interface
- `AWIDTH`, 16, byte-address width
- `DWIDTH`, 16, word width
- `WORDS_PER_BLOCK`, 8, words per cache block (power of two)
- `MEM_LATENCY`, 4, cycles from address issue to `memory_valid`

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `miss_detected`  in  1  cache reports miss this cycle
- `miss_address`  in  AWIDTH  byte address that missed
- `memory_valid`  in  1  `memory_data_out` holds returned data this cycle
- `memory_data_out`  in  DWIDTH  data returned by main memory
- `fsm_busy`  out  1  fill in progress; processor stalls
- `mem_enable`  out  1  `memory_address` is a valid read request this cycle
- `memory_address`  out  AWIDTH  word read address issued to main memory
- `write_data_array`  out  1  write `cache_data` at `cache_word_offset` this cycle
- `write_tag_array`  out  1  write tag/valid for the block this cycle
- `cache_word_offset`  out  log2(WORDS_PER_BLOCK)  word index within block being written
- `cache_data`  out  DWIDTH  data to write into the cache data array

## Operation
- **States:** IDLE and FILL. `fsm_busy` = (state == FILL).
- **IDLE:**
  - If `miss_detected` is high, latch `base` = `miss_address` with the low log2(2·WORDS_PER_BLOCK) bits cleared (0xFFF0 for the defaults).
  - Clear both counters and go to FILL. Otherwise stay in IDLE.
- **FILL, issue side:**
  - The issue counter `ic` runs 0..WORDS_PER_BLOCK and is 4 bits wide for the defaults.
  - While `ic` < WORDS_PER_BLOCK: `mem_enable`=1, `memory_address` = base + 2·`ic`, and `ic` increments.
  - Once `ic` = WORDS_PER_BLOCK: `mem_enable`=0 and `ic` holds.
- **FILL, return side:**
  - The receive counter is `rc`. On each `memory_valid`: `write_data_array`=1, `cache_word_offset`=`rc`, `cache_data`=`memory_data_out`, and `rc` increments.
  - On the valid that arrives with `rc` = WORDS_PER_BLOCK−1, `write_tag_array`=1 in that same cycle, and the next state is IDLE.
- **Output gating:**
  - `memory_address`=0 whenever `mem_enable`=0.
  - `cache_data`=0 and `cache_word_offset`=0 whenever `write_data_array`=0.
- **Address arithmetic:** 16-bit; base + 2·`ic` never carries out of the block.

## Timing
- **Reset values:** state IDLE, `ic`=`rc`=0, `base`=0. Every output is 0.
- **Miss seen in cycle 0 (defaults):**
  - FILL from cycle 1.
  - Addresses issued in cycles 1–8.
  - Data valid in cycles 5–12.
  - `write_tag_array` in cycle 12.
  - IDLE and `fsm_busy`=0 in cycle 13.
- **Total stall:** WORDS_PER_BLOCK + MEM_LATENCY cycles = 12.
- **Back-to-back misses:** a miss in cycle 13 is accepted immediately.
- **Boundary cases:**
  - `miss_detected` during FILL, including the final-data cycle, is ignored. The cache keeps asserting it, and it is taken in the first IDLE cycle.
  - `memory_valid` in IDLE is ignored: no writes occur.
  - Return-side writes never depend on `ic`. Overlap of issue and return (cycles 5–8) is normal.
  - `rst` mid-fill: IDLE on the next edge, with counters and outputs cleared. Main memory shares `rst`, so no stale returns arrive after reset.
  - `rst` has priority over `miss_detected` in the same cycle.

## Test plan
- **Basic fill:** reset, then `miss_address`=0x1236 in cycle 0.
  - Addresses 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - Data 0xA000+i returned in cycles 5–12 is written at offsets 0–7.
  - `write_tag_array` in cycle 12; `fsm_busy` high in cycles 1–12 only.
- **Block alignment:** miss at 0xFFFF.
  - Base is 0xFFF0 and the last address is 0xFFFE, with no wrap.
- **Ignored miss:** `miss_detected` with address 0x4000 at cycle 7 of a fill of 0x1230.
  - No change to `base` or the issued addresses.
  - A re-asserted miss in cycle 13 starts a new fill with base 0x4000.
- **Reset mid-fill:** `rst` in cycle 6 of a fill.
  - All outputs 0 in cycle 7; `fsm_busy`=0.
  - A subsequent miss fetches all 8 words correctly.
- **Spurious valid:** `memory_valid`=1 with data 0xDEAD while IDLE.
  - `write_data_array` and `write_tag_array` stay 0.
- **Parameter check:** `MEM_LATENCY`=1.
  - Data in cycles 2–9, tag write in cycle 9, IDLE in cycle 10.
